// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: bundle between the decode stage, the ID/EX pipeline register and the execute stage.
//
// Signals
//   flush, freeze       : pipeline control into the register
//   *_in                : decoded instruction bundle from decode
//   *_out               : registered bundle towards execute
//   bubble_cnt          : saturating count of bubbles loaded into execute
//
// Modports
//   master : pipeline side; drives flush/freeze and the *_in bundle, observes *_out/bubble_cnt
//   slave  : pipeline register; consumes the *_in bundle, drives *_out/bubble_cnt
interface id_ex_reg_if #(
  parameter int unsigned CNT_W = 16
);
  logic             flush;
  logic             freeze;

  logic [31:0]      PC_in;
  logic             WB_EN_in;
  logic             MEM_R_EN_in;
  logic             MEM_W_EN_in;
  logic             B_in;
  logic             S_in;
  logic [3:0]       EXE_CMD_in;
  logic [31:0]      Val_Rn_in;
  logic [31:0]      Val_Rm_in;
  logic             imm_in;
  logic [11:0]      Shift_operand_in;
  logic [23:0]      Signed_imm_24_in;
  logic [3:0]       Dest_in;
  logic [3:0]       SR_in;
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;

  logic [31:0]      PC_out;
  logic             WB_EN_out;
  logic             MEM_R_EN_out;
  logic             MEM_W_EN_out;
  logic             B_out;
  logic             S_out;
  logic [3:0]       EXE_CMD_out;
  logic [31:0]      Val_Rn_out;
  logic [31:0]      Val_Rm_out;
  logic             imm_out;
  logic [11:0]      Shift_operand_out;
  logic [23:0]      Signed_imm_24_out;
  logic [3:0]       Dest_out;
  logic [3:0]       SR_out;
  logic [3:0]       src1_out;
  logic [3:0]       src2_out;

  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output flush, freeze,
    output PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
    output Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    output Dest_in, SR_in, src1_in, src2_in,
    input  PC_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
    input  Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    input  Dest_out, SR_out, src1_out, src2_out,
    input  bubble_cnt
  );

  modport slave (
    input  flush, freeze,
    input  PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
    input  Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    input  Dest_in, SR_in, src1_in, src2_in,
    output PC_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
    output Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    output Dest_out, SR_out, src1_out, src2_out,
    output bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register of the 5-stage ARM-subset core.
//
// Captures the decoded bundle every edge and presents it to execute one cycle later.
// Edge priority: reset > freeze > flush > load. A flush loads an all-zero NOP.
// bubble_cnt counts entries loaded with no work (WB/MEM_R/MEM_W/B all low) and saturates.
//
// Ports
//   clk : core clock, rising edge
//   rst : asynchronous active-low reset
//   bus : id_ex_reg_if.slave (flush/freeze, *_in bundle in, *_out bundle and bubble_cnt out)
//
// Configuration
//   ID_EX_FWD_EN : when defined, src1/src2 register numbers are piped through for the
//                  forwarding unit; otherwise src1_out/src2_out are constant zero.
module id_ex_reg #(
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  id_ex_reg_if.slave bus
);

  logic [31:0]      r_pc;
  logic             r_wb_en;
  logic             r_mem_r_en;
  logic             r_mem_w_en;
  logic             r_b;
  logic             r_s;
  logic [3:0]       r_exe_cmd;
  logic [31:0]      r_val_rn;
  logic [31:0]      r_val_rm;
  logic             r_imm;
  logic [11:0]      r_shift_operand;
  logic [23:0]      r_signed_imm_24;
  logic [3:0]       r_dest;
  logic [3:0]       r_sr;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_bubble;
  logic             w_cnt_max;
  logic [CNT_W-1:0] w_cnt_inc;

  // The entry about to be loaded is a bubble when it is a flush NOP or carries no work.
  // S alone only updates flags and is not counted as work.
  always_comb begin
    w_bubble = bus.flush |
               ~(bus.WB_EN_in | bus.MEM_R_EN_in | bus.MEM_W_EN_in | bus.B_in);
  end

  assign w_cnt_max = &r_bubble_cnt;
  assign w_cnt_inc = r_bubble_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc            <= '0;
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_exe_cmd       <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_imm           <= 1'b0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_sr            <= '0;
    end else if (bus.freeze) begin
      // Stall: hold everything; a pending flush stays asserted upstream and lands later.
    end else if (bus.flush) begin
      r_pc            <= '0;
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_exe_cmd       <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_imm           <= 1'b0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_sr            <= '0;
    end else begin
      r_pc            <= bus.PC_in;
      r_wb_en         <= bus.WB_EN_in;
      r_mem_r_en      <= bus.MEM_R_EN_in;
      r_mem_w_en      <= bus.MEM_W_EN_in;
      r_b             <= bus.B_in;
      r_s             <= bus.S_in;
      r_exe_cmd       <= bus.EXE_CMD_in;
      r_val_rn        <= bus.Val_Rn_in;
      r_val_rm        <= bus.Val_Rm_in;
      r_imm           <= bus.imm_in;
      r_shift_operand <= bus.Shift_operand_in;
      r_signed_imm_24 <= bus.Signed_imm_24_in;
      r_dest          <= bus.Dest_in;
      r_sr            <= bus.SR_in;
    end
  end

  // Counter advances on the same edge that loads the bubble it counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (!bus.freeze && w_bubble && !w_cnt_max) begin
      r_bubble_cnt <= w_cnt_inc;
    end
  end

`ifdef ID_EX_FWD_EN
  logic [3:0] r_src1;
  logic [3:0] r_src2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src1 <= '0;
      r_src2 <= '0;
    end else if (bus.freeze) begin
      // hold
    end else if (bus.flush) begin
      r_src1 <= '0;
      r_src2 <= '0;
    end else begin
      r_src1 <= bus.src1_in;
      r_src2 <= bus.src2_in;
    end
  end

  assign bus.src1_out = r_src1;
  assign bus.src2_out = r_src2;
`else
  // Forwarding disabled: source numbers are not needed downstream.
  logic w_unused_src;
  assign w_unused_src = ^{bus.src1_in, bus.src2_in};

  assign bus.src1_out = 4'b0;
  assign bus.src2_out = 4'b0;
`endif

  assign bus.PC_out            = r_pc;
  assign bus.WB_EN_out         = r_wb_en;
  assign bus.MEM_R_EN_out      = r_mem_r_en;
  assign bus.MEM_W_EN_out      = r_mem_w_en;
  assign bus.B_out             = r_b;
  assign bus.S_out             = r_s;
  assign bus.EXE_CMD_out       = r_exe_cmd;
  assign bus.Val_Rn_out        = r_val_rn;
  assign bus.Val_Rm_out        = r_val_rm;
  assign bus.imm_out           = r_imm;
  assign bus.Shift_operand_out = r_shift_operand;
  assign bus.Signed_imm_24_out = r_signed_imm_24;
  assign bus.Dest_out          = r_dest;
  assign bus.SR_out            = r_sr;
  assign bus.bubble_cnt        = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed self-checking bench for id_ex_reg.
// A second instance with CNT_W=2 shares the stimulus and is used for counter saturation.
module tb_id_ex_reg;

  localparam int unsigned VW = 158;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_reg_if #(.CNT_W(16)) bus ();
  id_ex_reg_if #(.CNT_W(2))  bus2 ();

  id_ex_reg #(.CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  id_ex_reg #(.CNT_W(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  assign bus2.flush            = bus.flush;
  assign bus2.freeze           = bus.freeze;
  assign bus2.PC_in            = bus.PC_in;
  assign bus2.WB_EN_in         = bus.WB_EN_in;
  assign bus2.MEM_R_EN_in      = bus.MEM_R_EN_in;
  assign bus2.MEM_W_EN_in      = bus.MEM_W_EN_in;
  assign bus2.B_in             = bus.B_in;
  assign bus2.S_in             = bus.S_in;
  assign bus2.EXE_CMD_in       = bus.EXE_CMD_in;
  assign bus2.Val_Rn_in        = bus.Val_Rn_in;
  assign bus2.Val_Rm_in        = bus.Val_Rm_in;
  assign bus2.imm_in           = bus.imm_in;
  assign bus2.Shift_operand_in = bus.Shift_operand_in;
  assign bus2.Signed_imm_24_in = bus.Signed_imm_24_in;
  assign bus2.Dest_in          = bus.Dest_in;
  assign bus2.SR_in            = bus.SR_in;
  assign bus2.src1_in          = bus.src1_in;
  assign bus2.src2_in          = bus.src2_in;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [VW-1:0] exp_v;

  // Bundle order: {PC, WB, MR, MW, B, S, CMD, Rn, Rm, imm, shift, simm24, dest, SR, src1, src2}
  function automatic logic [VW-1:0] pack(
    input logic [31:0] pc, input logic [4:0] ctl, input logic [3:0] cmd,
    input logic [31:0] rn, input logic [31:0] rm, input logic imm,
    input logic [11:0] sh, input logic [23:0] si, input logic [3:0] dest,
    input logic [3:0] sr, input logic [3:0] s1, input logic [3:0] s2);
    return {pc, ctl, cmd, rn, rm, imm, sh, si, dest, sr, s1, s2};
  endfunction

  // Expected output for a loaded input vector: src fields only survive with forwarding.
  function automatic logic [VW-1:0] expect_of(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifndef ID_EX_FWD_EN
    r[7:0] = 8'h00;
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bus.PC_out, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out, bus.B_out,
            bus.S_out, bus.EXE_CMD_out, bus.Val_Rn_out, bus.Val_Rm_out, bus.imm_out,
            bus.Shift_operand_out, bus.Signed_imm_24_out, bus.Dest_out, bus.SR_out,
            bus.src1_out, bus.src2_out};
  endfunction

  task automatic drive(input logic [VW-1:0] v);
    {bus.PC_in, bus.WB_EN_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.B_in, bus.S_in,
     bus.EXE_CMD_in, bus.Val_Rn_in, bus.Val_Rm_in, bus.imm_in, bus.Shift_operand_in,
     bus.Signed_imm_24_in, bus.Dest_in, bus.SR_in, bus.src1_in, bus.src2_in} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] v;
    bus.flush = 1'b0;
    bus.freeze = 1'b0;
    v = pack(32'h1234_5678, 5'b10001, 4'hA, 32'h1111_2222, 32'h3333_4444, 1'b1,
             12'hABC, 24'h12_3456, 4'h7, 4'hF, 4'h6, 4'hB);
    drive(v);
    step();
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs %h, required 0", obs());
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    exp_v = expect_of(v);
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL first_load: outputs %h, required %h", obs(), exp_v);
    end
    // Asynchronous reset between edges, inputs still nonzero.
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== '0 || bus.bubble_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: outputs %h cnt %0d, required 0 and 0", obs(), bus.bubble_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(pack(32'h10, 5'b0, 4'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 12'h0, 24'h0, 4'h0, 4'h0,
               4'h0, 4'h0));
    step();
    exp_cnt = 1;  // zero-control load is a bubble
    checks++;
    if (bus.PC_out !== 32'h10 || bus.Val_Rn_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL reset_release: PC %h Rn %h, required 00000010 deadbeef",
               bus.PC_out, bus.Val_Rn_out);
    end
    checks++;
    if (bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL reset_release_cnt: cnt %0d, required %0d", bus.bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_pass_through();
    logic [VW-1:0] add_v;
    logic [VW-1:0] str_v;
    logic [VW-1:0] s_v;
    add_v = pack(32'h100, 5'b10000, 4'b0010, 32'd5, 32'd7, 1'b0, 12'h000, 24'h0, 4'd3,
                 4'b0100, 4'd1, 4'd2);
    str_v = pack(32'h104, 5'b00100, 4'b0010, 32'h8000_0000, 32'd9, 1'b1, 12'h004, 24'h0,
                 4'd0, 4'b0010, 4'd4, 4'd5);
    s_v   = pack(32'h108, 5'b00001, 4'b0100, 32'd1, 32'd1, 1'b0, 12'h000, 24'h0, 4'd0,
                 4'b0000, 4'd0, 4'd0);
    drive(add_v);
    step();
    drive(str_v);
    checks++;
    if (obs() !== expect_of(add_v) || bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL add_load: outputs %h cnt %0d, required %h cnt %0d",
               obs(), bus.bubble_cnt, expect_of(add_v), exp_cnt);
    end
    step();
    drive(s_v);
    checks++;
    if (obs() !== expect_of(str_v) || bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL str_load: outputs %h cnt %0d, required %h cnt %0d",
               obs(), bus.bubble_cnt, expect_of(str_v), exp_cnt);
    end
    step();
    exp_cnt++;  // S alone is still a bubble
    checks++;
    if (obs() !== expect_of(s_v) || bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL s_only_bubble: outputs %h cnt %0d, required %h cnt %0d",
               obs(), bus.bubble_cnt, expect_of(s_v), exp_cnt);
    end
    // Branch-only entry does work, no count.
    drive(pack(32'h10C, 5'b00010, 4'h0, 32'h0, 32'h0, 1'b0, 12'h0, 24'hFF_FFFE, 4'h0,
               4'h0, 4'h0, 4'h0));
    step();
    checks++;
    if (bus.B_out !== 1'b1 || bus.Signed_imm_24_out !== 24'hFF_FFFE ||
        bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL branch_load: B %b imm24 %h cnt %0d, required 1 fffffe %0d",
               bus.B_out, bus.Signed_imm_24_out, bus.bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush();
    drive(pack(32'h20, 5'b11110, 4'hF, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b1, 12'hFFF,
               24'hFF_FFFF, 4'hE, 4'hF, 4'd5, 4'd9));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    exp_cnt++;
    checks++;
    if (obs() !== '0 || bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL flush_nop: outputs %h cnt %0d, required 0 cnt %0d",
               obs(), bus.bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_freeze_flush();
    logic [VW-1:0] x_v;
    logic [VW-1:0] y_v;
    x_v = pack(32'h200, 5'b01000, 4'b0100, 32'd100, 32'd200, 1'b0, 12'h010, 24'h0, 4'd6,
               4'b1000, 4'd3, 4'd4);
    y_v = pack(32'h204, 5'b10000, 4'b1001, 32'd300, 32'd400, 1'b1, 12'h0F0, 24'h0, 4'd8,
               4'b0001, 4'd7, 4'd8);
    drive(x_v);
    step();
    drive(y_v);
    bus.freeze = 1'b1;
    bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== expect_of(x_v) || bus.bubble_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL freeze_hold_%0d: outputs %h cnt %0d, required %h cnt %0d",
                 i, obs(), bus.bubble_cnt, expect_of(x_v), exp_cnt);
      end
    end
    bus.freeze = 1'b0;
    step();
    exp_cnt++;
    checks++;
    if (obs() !== '0 || bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL unfreeze_flush: outputs %h cnt %0d, required 0 cnt %0d",
               obs(), bus.bubble_cnt, exp_cnt);
    end
    bus.flush = 1'b0;
    step();
    checks++;
    if (obs() !== expect_of(y_v) || bus.bubble_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL after_freeze_load: outputs %h cnt %0d, required %h cnt %0d",
               obs(), bus.bubble_cnt, expect_of(y_v), exp_cnt);
    end
  endtask

  task automatic test_fwd_fields();
    logic [3:0] e1;
    logic [3:0] e2;
`ifdef ID_EX_FWD_EN
    e1 = 4'd5;
    e2 = 4'd9;
`else
    e1 = 4'd0;
    e2 = 4'd0;
`endif
    drive(pack(32'h300, 5'b10000, 4'b0010, 32'd1, 32'd2, 1'b0, 12'h0, 24'h0, 4'd1, 4'h0,
               4'd5, 4'd9));
    step();
    checks++;
    if (bus.src1_out !== e1 || bus.src2_out !== e2) begin
      errors++;
      $display("FAIL fwd_load: src1 %0d src2 %0d, required %0d %0d",
               bus.src1_out, bus.src2_out, e1, e2);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    exp_cnt++;
    checks++;
    if (bus.src1_out !== 4'd0 || bus.src2_out !== 4'd0) begin
      errors++;
      $display("FAIL fwd_flush: src1 %0d src2 %0d, required 0 0", bus.src1_out, bus.src2_out);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1;
    exp_sat[1] = 2'd2;
    exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3;
    exp_sat[4] = 2'd3;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    checks++;
    if (bus2.bubble_cnt !== 2'd0) begin
      errors++;
      $display("FAIL sat_reset: cnt %0d, required 0", bus2.bubble_cnt);
    end
    drive(pack(32'h400, 5'b0, 4'h3, 32'd11, 32'd12, 1'b0, 12'h0, 24'h0, 4'd2, 4'h0,
               4'd0, 4'd0));
    for (int i = 0; i < 5; i++) begin
      step();
      exp_cnt++;
      checks++;
      if (bus2.bubble_cnt !== exp_sat[i] || bus.bubble_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_%0d: cnt2 %0d cnt16 %0d, required %0d %0d",
                 i, bus2.bubble_cnt, bus.bubble_cnt, exp_sat[i], exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_flush();
    test_freeze_flush();
    test_fwd_fields();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM-subset core. Each clock it captures the decoded control bundle, operand values, immediates, destination and PC+4 from the decode stage and presents them, one cycle later, to the execute stage. It implements pipeline flush on taken branch and freeze on memory stall. It also keeps a saturating count of bubbles that entered execute, for performance bring-up.

## Interface
Parameters:
- `CNT_W`, 16, width of the bubble counter

Ports:
- `clk` in 1: core clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `flush` in 1: taken branch from execute; squash the entry being loaded
- `freeze` in 1: memory stall; hold every register
- `PC_in` in 32: PC+4 of the decoded instruction
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in`, `B_in`, `S_in` in 1 each: decode control bits, already zeroed by decode on hazard or failed condition
- `EXE_CMD_in` in 4: ALU command
- `Val_Rn_in`, `Val_Rm_in` in 32 each: register-file read data
- `imm_in` in 1: immediate-operand flag
- `Shift_operand_in` in 12, `Signed_imm_24_in` in 24: instruction fields
- `Dest_in` in 4: destination register
- `SR_in` in 4: status flags {N,Z,C,V} at decode, used by execute for carry-in
- `src1_in`, `src2_in` in 4 each: source register numbers, used only with `ID_EX_FWD_EN`
- The outputs mirror each input: the same name with `_in` replaced by `_out` and the same width.
- `bubble_cnt` out `CNT_W`: saturating count of bubbles loaded

## Operation
- Priority on each rising edge: reset > freeze > flush > load.
- Reset (`rst`=0, asynchronous) clears every output register and `bubble_cnt` to 0. Release is synchronous to the next `clk` edge. Reset mid-stream discards the in-flight entry.
- Freeze=1: all registers, including `bubble_cnt`, hold their value. Freeze overrides flush. The branch source is itself frozen, so `flush` stays asserted and takes effect on the first unfrozen edge.
- Flush=1, freeze=0: all registers load 0. The output is then an all-zero NOP with every enable low, and `bubble_cnt` increments.
- Load (freeze=0, flush=0): every `_out` register loads its `_in` on the edge.
- Bubble definition: after a flush or a load, the entry is a bubble when `WB_EN_out`, `MEM_R_EN_out`, `MEM_W_EN_out` and `B_out` are all 0. `S_out` alone does not count as work. Each bubble entry increments `bubble_cnt` by 1.
- `bubble_cnt` saturates at 2^CNT_W−1 and never wraps.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: values present at edge N appear on outputs after edge N and stay stable until edge N+1.
- Reset takes effect on outputs with no clock edge required.
- Flush asserted in cycle N yields a NOP on the outputs in cycle N+1 (freeze low). The instruction decoded in cycle N is lost.
- Freeze asserted for K cycles holds the outputs for K cycles. The next entry loads on the first edge with freeze low.
- `bubble_cnt` updates on the same edge as the entry it counts.

## Configuration
- `ID_EX_FWD_EN` defined:
  - `src1_in`/`src2_in` are registered to `src1_out`/`src2_out` under the same reset/freeze/flush rules. Flush drives them to 0.
  - The forwarding unit in execute consumes them.
- Not defined:
  - `src1_in`/`src2_in` are ignored.
  - `src1_out`/`src2_out` are tied to 4'b0 and no flops are inferred.
  - All other behaviour is identical.

## Test plan
- Reset: drive all inputs nonzero, pull `rst` low between edges -> all outputs and `bubble_cnt` read 0 immediately. Release, load `PC_in`=0x10, `Val_Rn_in`=0xDEADBEEF -> both appear after the next edge.
- Pass-through: load ADD (`WB_EN_in`=1, `EXE_CMD_in`=4'b0010, `Dest_in`=3) then STR (`MEM_W_EN_in`=1) on consecutive edges -> outputs show each bundle exactly one cycle later; `bubble_cnt` stays 0.
- Flush: `flush`=1 for one edge while `WB_EN_in`=1, `PC_in`=0x20 -> next cycle all outputs are 0 and `bubble_cnt`=1.
- Freeze with flush: hold `freeze`=1 for 3 cycles with `flush`=1 throughout -> outputs and counter unchanged for 3 cycles. Freeze drops with flush still high -> NOP loaded and `bubble_cnt` +1.
- Saturation: set `CNT_W`=2 and load 5 zero-control entries -> `bubble_cnt` reads 1,2,3,3,3.
- Forwarding fields: with `ID_EX_FWD_EN`, `src1_in`=5 and `src2_in`=9 -> outputs 5/9 next cycle, and 0 after a flush. Without the macro -> both read 0 always.
